pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable inter-stage pipeline register with valid/ready
// handshake, synchronous flush (bubble insertion) and asynchronous reset.
// Optional skid buffer: define PIPE_SKID_EN to build the two-entry variant
// with a registered in_ready; undefined builds the single-register stage.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

`ifdef PIPE_SKID_EN

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              ready_q;
  logic              in_fire, out_fire;

  assign in_fire   = in_valid & ready_q;
  assign out_fire  = (state != EMPTY) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  // Next-state and datapath selection; flush overrides every other event.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = NOP_VALUE;
      skid_nxt  = NOP_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = TWO;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
            main_nxt  = NOP_VALUE;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
            skid_nxt  = NOP_VALUE;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = NOP_VALUE;
          skid_nxt  = NOP_VALUE;
        end
      endcase
    end
  end

  // State, payload and registered in_ready (computed from next state so it
  // tracks state != TWO without a combinational path from out_ready).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      main_q  <= main_nxt;
      skid_q  <= skid_nxt;
      ready_q <= (state_nxt != TWO);
    end
  end

`else

  logic              valid_q;
  logic [DATA_W-1:0] main_q;
  logic              in_fire, out_fire;

  assign in_ready  = ~valid_q | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = valid_q & out_ready;
  assign out_valid = valid_q;
  assign out_data  = main_q;

  // Single holding register: load on accept, drop to bubble on drain/flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      main_q  <= NOP_VALUE;
    end else if (flush) begin
      valid_q <= 1'b0;
      main_q  <= NOP_VALUE;
    end else if (in_fire) begin
      valid_q <= 1'b1;
      main_q  <= in_data;
    end else if (out_fire) begin
      valid_q <= 1'b0;
      main_q  <= NOP_VALUE;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard testbench for pipe_stage_reg (either PIPE_SKID_EN build).
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int unsigned CAP = SKID ? 2 : 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  in_data8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  out_data8;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned pops = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .NOP_VALUE(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  pipe_stage_reg #(.DATA_W(8), .NOP_VALUE(8'hFF)) dut8 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT state to the queue model, pop on output fire.
  always @(posedge clk) begin
    #3;
    if (!rst) begin
      chk("valid_vs_model", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (SKID) chk("ready_vs_model", {31'b0, in_ready}, {31'b0, q.size() < CAP});
      else      chk("ready_vs_model", {31'b0, in_ready}, {31'b0, (q.size() == 0) || out_ready});
      if (!out_valid) chk("bubble_data", out_data, 32'h0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("pop_empty", 32'h1, 32'h0);
        else begin
          chk("out_data_order", out_data, q.pop_front());
          pops++;
        end
      end
    end
  end

  // Stimulus side of the scoreboard: flush discards everything held,
  // otherwise an accepted input joins the tail of the expected queue.
  always @(posedge clk) begin
    #4;
    if (!rst) begin
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(in_data);
    end
  end

  task automatic offer(input logic [31:0] d, input bit ordy, input bit fl);
    int unsigned n = 0;
    bit done = 0;
    while (!done) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = d; out_ready = ordy; flush = fl;
      #1;
      if (in_ready) done = 1;
      else if (++n >= 50) begin
        chk("offer_timeout", 32'h0, 32'h1);
        done = 1;
      end
    end
  endtask

  task automatic idle(input bit ordy, input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; out_ready = ordy;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned idx, stall_acc, p0;

    // Reset held with an offer pending.
    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
      chk("rst_out_data8", {24'b0, out_data8}, 32'h0000_00FF);
    end
    #3; in_valid = 1'b0; rst = 1'b0;

    // Narrow instance: idle bubble is NOP_VALUE, 8'h01 passes through.
    @(posedge clk); #1; in_valid8 = 1'b1; in_data8 = 8'h01;
    @(posedge clk); #1; in_valid8 = 1'b0;
    #2;
    chk("w8_valid", {31'b0, out_valid8}, 32'h1);
    chk("w8_data", {24'b0, out_data8}, 32'h1);
    @(posedge clk); #3;
    chk("w8_idle", {24'b0, out_data8}, 32'h0000_00FF);

    // Streaming.
    offer(32'h1, 1, 0);
    offer(32'h2, 1, 0);
    offer(32'h3, 1, 0);
    idle(1, 4);
    chk("stream_drained", q.size(), 32'h0);

    // Back-pressure A0..A4.
    p0 = pops;
    offer(32'hA0, 1, 0);
    idx = 1; stall_acc = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'hA0 + idx; out_ready = 1'b0; flush = 1'b0;
      #1;
      if (in_ready) begin idx++; stall_acc++; end
    end
    chk("bp_stall_accepts", stall_acc, SKID ? 32'h1 : 32'h0);
    chk("bp_ready_low", {31'b0, in_ready}, 32'h0);
    while (idx < 5) begin
      offer(32'hA0 + idx, 1, 0);
      idx++;
    end
    idle(1, 5);
    chk("bp_delivered", pops - p0, 32'h5);
    chk("bp_drained", q.size(), 32'h0);

    // Flush with held entries and a simultaneous offer.
    offer(32'h55, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h66; out_ready = 1'b0;
    offer(32'h77, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_data", out_data, 32'h0);
    chk("flush_ready", {31'b0, in_ready}, 32'h1);
    idle(1, 3);

    // Asynchronous reset while an entry is held.
    offer(32'hC0FFEE, 0, 0);
    @(posedge clk); #1; in_valid = 1'b0;
    #1;
    chk("arst_pre_valid", {31'b0, out_valid}, 32'h1);
    #4; rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_data", out_data, 32'h0);
    chk("arst_ready", {31'b0, in_ready}, 32'h1);
    q.delete();
    @(posedge clk); #6; rst = 1'b0;

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
    end
    idle(1, 5);
    chk("final_drained", q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
